// File: rtl/key_bounce_gen.sv
// Mechanical key bounce generator: drives active-low key lines through a bounced
// press, a steady hold, and a bounced release, with segment lengths from an LFSR.
module key_bounce_gen #(
  parameter int unsigned KEY_W      = 3,
  parameter int unsigned BOUNCE_CNT = 4,
  parameter int unsigned BOUNCE_LOG = 4,
  parameter int unsigned HOLD_TIME  = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_mask,
  output logic [KEY_W-1:0] key_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SEG_N     = 2 * BOUNCE_CNT;
  localparam int unsigned SEG_W     = (SEG_N == 0) ? 1 : $clog2(SEG_N + 1);
  localparam int unsigned SEG_MAX   = 1 << BOUNCE_LOG;
  localparam int unsigned CNT_MAX   = (HOLD_TIME > SEG_MAX) ? HOLD_TIME : SEG_MAX;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d, seg_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_run, seg_len;
  logic             first_q, first_d;
  logic [KEY_W-1:0] mask_q, mask_d;
  logic [KEY_W-1:0] key_d;
  logic             busy_d, done_d, low_d, seg_end;
  logic [15:0]      lfsr_q;
  logic             lfsr_fb;

  // Taps for x^16+x^14+x^13+x^11+1 in right-shift form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Next state plus the registered output values for the following cycle
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    low_d   = 1'b0;
    seg_len = CNT_W'(lfsr_q[BOUNCE_LOG-1:0]);
    seg_end = first_q ? (seg_len == '0) : (cnt_q == '0);
    cnt_run = first_q ? (seg_len - CNT_W'(1)) : (cnt_q - CNT_W'(1));
    seg_inc = seg_q + SEG_W'(1);

    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          if (key_mask != '0) begin
            mask_d  = key_mask;
            seg_d   = '0;
            first_d = 1'b1;
            cnt_d   = CNT_W'(HOLD_TIME - 1);
            state_d = (SEG_N == 0) ? HOLD : PRESS_BOUNCE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PRESS_BOUNCE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (seg_end) begin
          first_d = 1'b1;
          if (seg_inc == SEG_W'(SEG_N)) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLD_TIME - 1);
          end else begin
            seg_d = seg_inc;
          end
        end else begin
          first_d = 1'b0;
          cnt_d   = cnt_run;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RELEASE_BOUNCE;
          seg_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE_BOUNCE: begin
        // seg_q == SEG_N is the final released cycle before FINISH
        if (abort) begin
          state_d = IDLE;
        end else if (seg_q == SEG_W'(SEG_N)) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (seg_end) begin
          seg_d   = seg_inc;
          first_d = 1'b1;
        end else begin
          first_d = 1'b0;
          cnt_d   = cnt_run;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Even press segments and odd release segments hold the lines low
    case (state_d)
      PRESS_BOUNCE: begin
        busy_d = 1'b1;
        low_d  = ~seg_d[0];
      end
      HOLD: begin
        busy_d = 1'b1;
        low_d  = 1'b1;
      end
      RELEASE_BOUNCE: begin
        busy_d = 1'b1;
        low_d  = seg_d[0];
      end
      default: begin
        busy_d = 1'b0;
        low_d  = 1'b0;
      end
    endcase

    key_d = ~(mask_d & {KEY_W{low_d}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seg_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      mask_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      key_out <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      mask_q  <= mask_d;
      lfsr_q  <= {lfsr_fb, lfsr_q[15:1]};
      key_out <= key_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Scoreboard bench for key_bounce_gen: a clean-edge and a bounced instance share
// stimulus; a trace model built from the sequence rules predicts every output cycle.
module tb_key_bounce_gen;

  typedef struct packed {
    logic [2:0] key;
    logic       busy;
    logic       done;
  } exp_t;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam exp_t        IDLE_E = {3'b111, 1'b0, 1'b0};
  localparam exp_t        DONE_E = {3'b111, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] key_mask = 3'b000;
  logic [2:0] key_c, key_b;
  logic       busy_c, busy_b, done_c, done_b;

  key_bounce_gen #(.KEY_W(3), .BOUNCE_CNT(0), .BOUNCE_LOG(4), .HOLD_TIME(10)) u_clean (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_mask(key_mask),
    .key_out(key_c), .busy(busy_c), .done(done_c)
  );

  key_bounce_gen #(.KEY_W(3), .BOUNCE_CNT(2), .BOUNCE_LOG(2), .HOLD_TIME(20)) u_bnc (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_mask(key_mask),
    .key_out(key_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  exp_t        sb_c[$], sb_b[$], tr_c[$], tr_b[$];
  bit          act_c = 1'b0, act_b = 1'b0;
  logic [15:0] lf = SEED;
  int          checks = 0, errors = 0;
  int          rel_c = 0, rel_b = 0;
  bit          cnt_en = 1'b0;
  int          falls_c = 0, rises_c = 0, falls_b = 0, rises_b = 0;
  logic        prev_c0 = 1'b1, prev_b0 = 1'b1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  // Full expected trace of one press/release, starting at the cycle after start
  task automatic build(input int b, input int bl, input int h, input logic [2:0] m,
                       input logic [15:0] v0, ref exp_t tr[$], ref int rel);
    logic [15:0] v;
    int          len;
    exp_t        lo, hi;
    v  = v0;
    lo = {~m, 1'b1, 1'b0};
    hi = {3'b111, 1'b1, 1'b0};
    tr.delete();
    for (int i = 0; i < 2 * b; i++) begin
      len = 1 + (int'(v) % (1 << bl));
      for (int k = 0; k < len; k++) begin
        tr.push_back((i % 2 == 0) ? lo : hi);
        v = lfsr_next(v);
      end
    end
    for (int k = 0; k < h; k++) begin
      tr.push_back(lo);
      v = lfsr_next(v);
    end
    rel = 2;
    for (int i = 0; i < 2 * b; i++) begin
      len = 1 + (int'(v) % (1 << bl));
      for (int k = 0; k < len; k++) begin
        tr.push_back((i % 2 == 0) ? hi : lo);
        v = lfsr_next(v);
        rel++;
      end
    end
    tr.push_back(hi);
    tr.push_back(DONE_E);
  endtask

  // act = the DUT is outside IDLE during the cycle whose inputs are being applied
  task automatic model(input int b, input int bl, input int h, input logic r, input logic a,
                       input logic s, input logic [2:0] m, input logic [15:0] lf_cur,
                       ref exp_t tr[$], ref exp_t sb[$], ref bit act, ref int rel);
    if (r) begin
      tr.delete();
      act = 1'b0;
      sb.push_back(IDLE_E);
    end else if (act) begin
      if (a || tr.size() == 0) begin
        tr.delete();
        act = 1'b0;
        sb.push_back(IDLE_E);
      end else begin
        sb.push_back(tr.pop_front());
      end
    end else if (!a && s && m != 3'b000) begin
      build(b, bl, h, m, lfsr_next(lf_cur), tr, rel);
      sb.push_back(tr.pop_front());
      act = 1'b1;
    end else if (!a && s) begin
      sb.push_back(DONE_E);
    end else begin
      sb.push_back(IDLE_E);
    end
  endtask

  task automatic cyc(input logic r, input logic a, input logic s, input logic [2:0] m);
    @(negedge clk);
    #1;
    rst      = r;
    abort    = a;
    start    = s;
    key_mask = m;
    model(0, 4, 10, r, a, s, m, lf, tr_c, sb_c, act_c, rel_c);
    model(2, 2, 20, r, a, s, m, lf, tr_b, sb_b, act_b, rel_b);
    lf = r ? SEED : lfsr_next(lf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: one expected entry per instance per output cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb_c.size() > 0) begin
      e = sb_c.pop_front();
      checks++;
      if (exp_t'({key_c, busy_c, done_c}) !== e) begin
        errors++;
        $display("FAIL clean_out t=%0t: got key=%b busy=%b done=%b, expected key=%b busy=%b done=%b",
                 $time, key_c, busy_c, done_c, e.key, e.busy, e.done);
      end
    end
    if (sb_b.size() > 0) begin
      e = sb_b.pop_front();
      checks++;
      if (exp_t'({key_b, busy_b, done_b}) !== e) begin
        errors++;
        $display("FAIL bounce_out t=%0t: got key=%b busy=%b done=%b, expected key=%b busy=%b done=%b",
                 $time, key_b, busy_b, done_b, e.key, e.busy, e.done);
      end
    end
  end

  // Edge counter on line 0 of both instances
  always @(negedge clk) begin
    if (cnt_en) begin
      if (prev_c0 && !key_c[0]) falls_c++;
      if (!prev_c0 && key_c[0]) rises_c++;
      if (prev_b0 && !key_b[0]) falls_b++;
      if (!prev_b0 && key_b[0]) rises_b++;
    end
    prev_c0 = key_c[0];
    prev_b0 = key_b[0];
  end

  task automatic start_after_reset(input logic [2:0] m);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    idle(7);
    cyc(1'b0, 1'b0, 1'b1, m);
  endtask

  initial begin
    int k;
    // First run after power-up, reset in the middle of the bounced release
    start_after_reset(3'b001);
    k = 0;
    while (tr_b.size() != rel_b - 3 && k < 200) begin
      idle(1);
      k++;
    end
    if (k >= 200) begin
      errors++;
      $display("FAIL release_wait: never reached release phase, remaining=%0d", tr_b.size());
    end

    // Same offset after reset: identical segments, with edge counts on line 0
    start_after_reset(3'b001);
    falls_c = 0; rises_c = 0; falls_b = 0; rises_b = 0;
    cnt_en = 1'b1;
    idle(70);
    cnt_en = 1'b0;
    chk("bounce_falls", falls_b, 5);
    chk("bounce_rises", rises_b, 5);
    chk("clean_falls", falls_c, 1);
    chk("clean_rises", rises_c, 1);

    // Clean press on the middle line
    cyc(1'b0, 1'b0, 1'b1, 3'b010);
    idle(70);

    // Empty mask
    cyc(1'b0, 1'b0, 1'b1, 3'b000);
    idle(3);

    // Abort in the clean hold window, then in the bounced hold window
    cyc(1'b0, 1'b0, 1'b1, 3'b011);
    idle(5);
    cyc(1'b0, 1'b1, 1'b0, 3'b000);
    idle(70);
    cyc(1'b0, 1'b0, 1'b1, 3'b011);
    idle(19);
    cyc(1'b0, 1'b1, 1'b0, 3'b000);
    idle(70);

    // Abort with start in IDLE
    cyc(1'b0, 1'b1, 1'b1, 3'b101);
    idle(3);

    // Starts while busy are ignored
    cyc(1'b0, 1'b0, 1'b1, 3'b100);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 3'b011);
    idle(9);
    cyc(1'b0, 1'b0, 1'b1, 3'b111);
    idle(70);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 400) == 0, ($urandom % 80) == 0, ($urandom % 6) == 0, 3'($urandom));
    end
    idle(80);
    @(negedge clk);
    @(negedge clk);
    chk("sb_clean_drained", sb_c.size(), 0);
    chk("sb_bounce_drained", sb_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
